// File: rtl/wfg_timing_core.sv
// Waveform-generator timing core: subcycle/sync strobe generation with optional burst length.
// Define WFG_CORE_RELOAD_EN to re-latch the subcycle and sync thresholds on every sync strobe.
module wfg_timing_core #(
    parameter int SUB_W   = 16,
    parameter int SYNC_W  = 8,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic               mode_i,
    input  logic [SUB_W-1:0]   subcycle_count_i,
    input  logic [SYNC_W-1:0]  sync_count_i,
    input  logic [BURST_W-1:0] burst_len_i,
    output logic               start_o,
    output logic               subcycle_o,
    output logic               sync_o,
    output logic [SYNC_W-1:0]  subcycle_cnt_o,
    output logic [BURST_W-1:0] sync_cnt_o,
    output logic               active_o,
    output logic               done_o
);

`ifdef WFG_CORE_RELOAD_EN
    localparam bit RELOAD = 1'b1;
`else
    localparam bit RELOAD = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [SUB_W-1:0]     div_q, div_d;
    logic [SUB_W-1:0]     sub_thr_q, sub_thr_d;
    logic [SYNC_W-1:0]    sync_thr_q, sync_thr_d;
    logic [BURST_W-1:0]   burst_len_q, burst_len_d;
    logic                 burst_mode_q, burst_mode_d;

    logic                 start_d, subcycle_d, sync_d, active_d, done_d;
    logic [SYNC_W-1:0]    subcycle_cnt_d;
    logic [BURST_W-1:0]   sync_cnt_d;

    logic                 strobe_due, sync_due, burst_end;
    logic [BURST_W-1:0]   sync_cnt_inc;

    assign strobe_due   = (div_q == sub_thr_q);
    assign sync_due     = strobe_due && (subcycle_cnt_o == sync_thr_q);
    // Burst ends where sync strobe B+1 would be emitted, i.e. B syncs already counted.
    assign burst_end    = sync_due && burst_mode_q && (burst_len_q != '0)
                          && (sync_cnt_o == burst_len_q);
    assign sync_cnt_inc = (sync_cnt_o == {BURST_W{1'b1}}) ? sync_cnt_o : sync_cnt_o + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (en_i) state_d = RUN;
            RUN: begin
                if (!en_i) begin
                    state_d = IDLE;
                end else if (burst_end) begin
                    state_d = DONE;
                end
            end
            DONE: if (!en_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_d        = 1'b0;
        subcycle_d     = 1'b0;
        sync_d         = 1'b0;
        active_d       = 1'b0;
        done_d         = 1'b0;
        subcycle_cnt_d = '0;
        sync_cnt_d     = '0;
        div_d          = '0;
        sub_thr_d      = sub_thr_q;
        sync_thr_d     = sync_thr_q;
        burst_len_d    = burst_len_q;
        burst_mode_d   = burst_mode_q;
        case (state_q)
            IDLE: begin
                if (en_i) begin
                    start_d      = 1'b1;
                    subcycle_d   = 1'b1;
                    sync_d       = 1'b1;
                    active_d     = 1'b1;
                    sync_cnt_d   = {{(BURST_W-1){1'b0}}, 1'b1};
                    sub_thr_d    = subcycle_count_i;
                    sync_thr_d   = sync_count_i;
                    burst_len_d  = burst_len_i;
                    burst_mode_d = mode_i;
                end
            end
            RUN: begin
                if (en_i && burst_end) begin
                    done_d     = 1'b1;
                    sync_cnt_d = sync_cnt_o;
                end else if (en_i) begin
                    active_d       = 1'b1;
                    subcycle_cnt_d = subcycle_cnt_o;
                    sync_cnt_d     = sync_cnt_o;
                    if (!strobe_due) begin
                        div_d = div_q + 1'b1;
                    end else if (sync_due) begin
                        subcycle_d     = 1'b1;
                        sync_d         = 1'b1;
                        subcycle_cnt_d = '0;
                        sync_cnt_d     = sync_cnt_inc;
                        if (RELOAD) begin
                            sub_thr_d  = subcycle_count_i;
                            sync_thr_d = sync_count_i;
                        end
                    end else begin
                        subcycle_d     = 1'b1;
                        subcycle_cnt_d = subcycle_cnt_o + 1'b1;
                    end
                end
            end
            DONE: begin
                if (en_i) begin
                    done_d     = 1'b1;
                    sync_cnt_d = sync_cnt_o;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs, counters and latched configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_o        <= 1'b0;
            subcycle_o     <= 1'b0;
            sync_o         <= 1'b0;
            active_o       <= 1'b0;
            done_o         <= 1'b0;
            subcycle_cnt_o <= '0;
            sync_cnt_o     <= '0;
            div_q          <= '0;
            sub_thr_q      <= '0;
            sync_thr_q     <= '0;
            burst_len_q    <= '0;
            burst_mode_q   <= 1'b0;
        end else begin
            start_o        <= start_d;
            subcycle_o     <= subcycle_d;
            sync_o         <= sync_d;
            active_o       <= active_d;
            done_o         <= done_d;
            subcycle_cnt_o <= subcycle_cnt_d;
            sync_cnt_o     <= sync_cnt_d;
            div_q          <= div_d;
            sub_thr_q      <= sub_thr_d;
            sync_thr_q     <= sync_thr_d;
            burst_len_q    <= burst_len_d;
            burst_mode_q   <= burst_mode_d;
        end
    end

endmodule

// File: tb/tb_wfg_timing_core.sv
// Self-checking bench for wfg_timing_core: directed scenarios plus random enable/config
// traffic compared against an arithmetic model (strobe times derived from cycles since start).
module tb_wfg_timing_core;

    localparam int SUB_W   = 16;
    localparam int SYNC_W  = 8;
    localparam int BURST_W = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en_i = 1'b0;
    logic               mode_i = 1'b0;
    logic [SUB_W-1:0]   subcycle_count_i = '0;
    logic [SYNC_W-1:0]  sync_count_i = '0;
    logic [BURST_W-1:0] burst_len_i = '0;
    logic               start_o, subcycle_o, sync_o, active_o, done_o;
    logic [SYNC_W-1:0]  subcycle_cnt_o;
    logic [BURST_W-1:0] sync_cnt_o;

    wfg_timing_core #(.SUB_W(SUB_W), .SYNC_W(SYNC_W), .BURST_W(BURST_W)) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .mode_i(mode_i),
        .subcycle_count_i(subcycle_count_i), .sync_count_i(sync_count_i),
        .burst_len_i(burst_len_i), .start_o(start_o), .subcycle_o(subcycle_o),
        .sync_o(sync_o), .subcycle_cnt_o(subcycle_cnt_o), .sync_cnt_o(sync_cnt_o),
        .active_o(active_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: 0 idle, 1 run, 2 done; mK counts clocks since the start strobe.
    int mState = 0;
    int mK = 0, mS = 0, mY = 0, mB = 0;
    bit mMode = 1'b0;
    bit modelOn = 1'b1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkAll();
        int n, expSub, expSync, expIdx, expCnt;
        if (mState == 1) begin
            n       = mK / (mS + 1);
            expSub  = ((mK % (mS + 1)) == 0) ? 1 : 0;
            expIdx  = n % (mY + 1);
            expSync = (expSub == 1 && expIdx == 0) ? 1 : 0;
            expCnt  = n / (mY + 1) + 1;
            if (expCnt > 255) expCnt = 255;
            checkOutput("start", start_o, (mK == 0) ? 1 : 0);
            checkOutput("subcycle", subcycle_o, expSub);
            checkOutput("sync", sync_o, expSync);
            checkOutput("subIdx", subcycle_cnt_o, expIdx);
            checkOutput("syncCnt", sync_cnt_o, expCnt);
            checkOutput("active", active_o, 1);
            checkOutput("done", done_o, 0);
        end else begin
            checkOutput("start", start_o, 0);
            checkOutput("subcycle", subcycle_o, 0);
            checkOutput("sync", sync_o, 0);
            checkOutput("subIdx", subcycle_cnt_o, 0);
            checkOutput("syncCnt", sync_cnt_o, (mState == 2) ? mB : 0);
            checkOutput("active", active_o, 0);
            checkOutput("done", done_o, (mState == 2) ? 1 : 0);
        end
    endtask

    task automatic modelStep(input bit en, input int s, input int y, input int b, input bit m);
        int k2, n;
        case (mState)
            0: if (en) begin
                mState = 1; mK = 0; mS = s; mY = y; mB = b; mMode = m;
            end
            1: if (!en) begin
                mState = 0;
            end else begin
                k2 = mK + 1;
                n  = k2 / (mS + 1);
                if (mMode && mB != 0 && (k2 % (mS + 1)) == 0 && (n % (mY + 1)) == 0
                    && (n / (mY + 1)) == mB)
                    mState = 2;
                else
                    mK = k2;
            end
            default: if (!en) mState = 0;
        endcase
    endtask

    // One clock: drive inputs at the falling edge, step the model at the rising edge, check at the next falling edge.
    task automatic applyStimulus(input bit en, input int s, input int y, input int b, input bit m);
        en_i             = en;
        subcycle_count_i = SUB_W'(s);
        sync_count_i     = SYNC_W'(y);
        burst_len_i      = BURST_W'(b);
        mode_i           = m;
        @(posedge clk);
        modelStep(en, s, y, b, m);
        @(negedge clk);
        if (modelOn) checkAll();
    endtask

    task automatic doReset();
        #2 rst = 1'b1;
        #1 mState = 0;
        checkAll();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int strobes[$];
        int s, y, b;
        bit m, en, chg;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkAll();

        // Continuous run, S=3 Y=2
        repeat (10) applyStimulus(0, 3, 2, 0, 0);
        for (int i = 0; i < 13; i++) applyStimulus(1, 3, 2, 0, 0);
        checkOutput("contSyncAt12", sync_o, 1);
        checkOutput("contIdxAt12", subcycle_cnt_o, 0);

        // Burst S=1 Y=1 B=2
        repeat (2) applyStimulus(0, 1, 1, 2, 1);
        for (int i = 0; i < 9; i++) applyStimulus(1, 1, 1, 2, 1);
        checkOutput("burstDone", done_o, 1);
        checkOutput("burstCnt", sync_cnt_o, 2);
        checkOutput("burstActive", active_o, 0);
        repeat (3) applyStimulus(1, 1, 1, 2, 1);
        applyStimulus(0, 1, 1, 2, 1);
        checkOutput("burstDoneClr", done_o, 0);

        // Minimum periods and sync counter saturation
        for (int i = 0; i < 255; i++) applyStimulus(1, 0, 0, 0, 0);
        checkOutput("satCnt", sync_cnt_o, 255);
        repeat (5) applyStimulus(1, 0, 0, 0, 0);
        checkOutput("satHold", sync_cnt_o, 255);

        // Disable one cycle before a scheduled strobe, then restart
        applyStimulus(0, 3, 2, 0, 0);
        repeat (4) applyStimulus(1, 3, 2, 0, 0);
        applyStimulus(0, 3, 2, 0, 0);
        checkOutput("disableNoStrobe", subcycle_o, 0);
        applyStimulus(1, 3, 2, 0, 0);
        checkOutput("restartStart", start_o, 1);
        repeat (3) applyStimulus(1, 3, 2, 0, 0);

        // Reset mid-run while subcycle index is 1
        applyStimulus(0, 2, 2, 0, 0);
        repeat (4) applyStimulus(1, 2, 2, 0, 0);
        checkOutput("preResetIdx", subcycle_cnt_o, 1);
        doReset();
        applyStimulus(1, 2, 2, 0, 0);
        checkOutput("postResetStart", start_o, 1);
        repeat (3) applyStimulus(1, 2, 2, 0, 0);

        // Random traffic
        en = 1'b0; s = 0; y = 0; b = 0; m = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) en = ~en;
            chg = !en;
`ifndef WFG_CORE_RELOAD_EN
            chg = 1'b1;
`endif
            if (chg) begin
                s = $urandom_range(3);
                y = $urandom_range(3);
                b = $urandom_range(3);
                m = 1'($urandom_range(1));
            end
            applyStimulus(en, s, y, b, m);
        end

        // Config change mid sync period: S 3 -> 5 with Y=1
        modelOn = 1'b0;
        applyStimulus(0, 3, 1, 0, 0);
        for (int i = 0; i < 22; i++) begin
            applyStimulus(1, (i >= 2) ? 5 : 3, 1, 0, 0);
            if (subcycle_o) strobes.push_back(i);
        end
        checkOutput("cfgStrobeCount", (strobes.size() >= 4) ? 1 : 0, 1);
        checkOutput("cfgStrobe1", (strobes.size() > 1) ? strobes[1] : -1, 4);
        checkOutput("cfgStrobe2", (strobes.size() > 2) ? strobes[2] : -1, 8);
`ifdef WFG_CORE_RELOAD_EN
        checkOutput("cfgStrobe3", (strobes.size() > 3) ? strobes[3] : -1, 14);
`else
        checkOutput("cfgStrobe3", (strobes.size() > 3) ? strobes[3] : -1, 12);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
